// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler time-sharing one pipelined fp_add
// between N_REQ requesters, with tag-based response routing and an alignment check.
module fp_add_sched #(
   parameter int N_REQ   = 4,
   parameter int I_EXP   = 8,
   parameter int I_MNT   = 23,
   parameter int I_DATA  = I_EXP + I_MNT + 1,
   parameter int ADD_LAT = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        hold,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*I_DATA-1:0]     req_a,
   input  logic [N_REQ*I_DATA-1:0]     req_b,
   output logic [N_REQ-1:0]            req_ready,
   output logic [I_DATA-1:0]           add_a,
   output logic [I_DATA-1:0]           add_b,
   output logic                        add_in_valid,
   input  logic [I_DATA-1:0]           add_result,
   input  logic                        add_out_valid,
   output logic [N_REQ-1:0]            resp_valid,
   output logic [I_DATA-1:0]           resp_data,
   output logic [$clog2(ADD_LAT+2):0]  inflight,
   output logic                        err
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(ADD_LAT+2) + 1;

   logic [ID_W-1:0]    last;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    add_id;
   logic               found;
   logic               hold_i;
   logic               hs;
   logic [I_DATA-1:0]  sel_a;
   logic [I_DATA-1:0]  sel_b;
   logic [ADD_LAT-1:0] tag_v;
   logic [ID_W-1:0]    tag_id [ADD_LAT];
   logic [CNT_W-1:0]   mask;

   // base + k modulo N_REQ, with k in 1..N_REQ so one subtraction suffices
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return ID_W'(s);
   endfunction

   always_comb begin
      found    = 1'b0;
      grant_id = last;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req_valid[wrap_idx(last, k)]) begin
            found    = 1'b1;
            grant_id = wrap_idx(last, k);
         end
      end
      hold_i    = hold | ~reset;
      hs        = found & ~hold_i;
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (hs && grant_id == ID_W'(i)) begin
            req_ready[i] = 1'b1;
            sel_a        = req_a[i*I_DATA +: I_DATA];
            sel_b        = req_b[i*I_DATA +: I_DATA];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         add_in_valid <= 1'b0;
         add_a        <= '0;
         add_b        <= '0;
         add_id       <= '0;
         last         <= ID_W'(N_REQ - 1);
         tag_v        <= '0;
         for (int k = 0; k < ADD_LAT; k++) tag_id[k] <= '0;
         resp_valid   <= '0;
         resp_data    <= '0;
         inflight     <= '0;
         mask         <= CNT_W'(ADD_LAT + 1);
         err          <= 1'b0;
      end else begin
         add_in_valid <= hs;
         if (hs) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            add_id <= grant_id;
            last   <= grant_id;
         end
         // stage 0 follows the registered issue so the last stage lines up with add_out_valid
         tag_v[0]  <= add_in_valid;
         tag_id[0] <= add_id;
         for (int k = 1; k < ADD_LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
         if (tag_v[ADD_LAT-1]) begin
            resp_valid <= N_REQ'(1) << tag_id[ADD_LAT-1];
            resp_data  <= add_result;
         end else begin
            resp_valid <= '0;
         end
         if (hs && !tag_v[ADD_LAT-1])
            inflight <= inflight + CNT_W'(1);
         else if (!hs && tag_v[ADD_LAT-1])
            inflight <= inflight - CNT_W'(1);
         if (mask != '0)
            mask <= mask - CNT_W'(1);
         else if (add_out_valid != tag_v[ADD_LAT-1])
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - directed self-checking bench for fp_add_sched
// with a behavioural pipelined adder that can be skewed one cycle late.
module tb_fp_add_sched;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int LAT = 3;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 hold = 1'b0;
   logic [N-1:0]         req_valid = '0;
   logic [N*DW-1:0]      req_a = '0;
   logic [N*DW-1:0]      req_b = '0;
   logic [N-1:0]         req_ready;
   logic [DW-1:0]        add_a;
   logic [DW-1:0]        add_b;
   logic                 add_in_valid;
   logic [DW-1:0]        add_result;
   logic                 add_out_valid;
   logic [N-1:0]         resp_valid;
   logic [DW-1:0]        resp_data;
   logic [$clog2(LAT+2):0] inflight;
   logic                 err;

   int n_chk = 0;
   int n_fail = 0;

   fp_add_sched #(.N_REQ(N), .I_EXP(8), .I_MNT(23), .I_DATA(DW), .ADD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .hold(hold),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_in_valid(add_in_valid),
      .add_result(add_result), .add_out_valid(add_out_valid),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .inflight(inflight), .err(err)
   );

   always #5 clk = ~clk;

   // integer-valued positive floats only, enough for the directed vectors
   function automatic int fp2int(input logic [31:0] f);
      int m;
      int e;
      if (f[30:23] == 8'd0) return 0;
      m = int'({8'h00, 1'b1, f[22:0]});
      e = int'(f[30:23]) - 127;
      return m >> (23 - e);
   endfunction

   function automatic logic [31:0] int2fp(input int v);
      int p;
      logic [31:0] sh;
      if (v == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 24; i++) if (v[i]) p = i;
      sh = 32'(v) << (23 - p);
      return {1'b0, 8'(127 + p), sh[22:0]};
   endfunction

   logic          late = 1'b0;
   logic          pv [LAT+1] = '{default: 1'b0};
   logic [DW-1:0] pd [LAT+1] = '{default: '0};

   always @(posedge clk) begin
      pv[0] <= add_in_valid;
      pd[0] <= int2fp(fp2int(add_a) + fp2int(add_b));
      for (int k = 1; k <= LAT; k++) begin
         pv[k] <= pv[k-1];
         pd[k] <= pd[k-1];
      end
   end

   assign add_out_valid = late ? pv[LAT] : pv[LAT-1];
   assign add_result    = late ? pd[LAT] : pd[LAT-1];

   typedef struct {
      logic [N-1:0]  rv;
      logic [DW-1:0] data;
      int            cyc;
   } resp_t;

   resp_t rq[$];
   int    cyc = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (resp_valid != '0) rq.push_back('{resp_valid, resp_data, cyc});
   end

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] onehot(input int id);
      return N'(1) << id;
   endfunction

   task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
      req_a[id*DW +: DW] = a;
      req_b[id*DW +: DW] = b;
   endtask

   task automatic do_reset();
      req_valid = '1;
      reset     = 1'b0;
      #1;
      chk("ready_in_reset", req_ready, '0);
      tick();
      reset     = 1'b1;
      req_valid = '0;
      #1;
      chk("rst_add_in_valid", add_in_valid, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_err", err, 0);
   endtask

   vec_t          vecs[6];
   logic [31:0]   exp_c[4];
   int            peak;

   initial begin
      vecs[0] = '{2, 32'h3F800000, 32'h3F800000, 32'h40000000};
      vecs[1] = '{0, 32'h40000000, 32'h3F800000, 32'h40400000};
      vecs[2] = '{3, 32'h40400000, 32'h3F800000, 32'h40800000};
      vecs[3] = '{1, 32'h00000000, 32'h3F800000, 32'h3F800000};
      vecs[4] = '{0, 32'h40000000, 32'h40000000, 32'h40800000};
      vecs[5] = '{3, 32'h40800000, 32'h40800000, 32'h41000000};
      exp_c[0] = 32'h3F800000;
      exp_c[1] = 32'h40000000;
      exp_c[2] = 32'h40400000;
      exp_c[3] = 32'h40800000;

      do_reset();

      // isolated single operations: grant, 5-cycle latency, routing, data
      for (int v = 0; v < 6; v++) begin
         set_op(vecs[v].id, vecs[v].a, vecs[v].b);
         req_valid = onehot(vecs[v].id);
         #1;
         chk("single_grant", req_ready, onehot(vecs[v].id));
         tick();
         req_valid = '0;
         for (int k = 1; k <= 6; k++) begin
            if (k == 1) chk("single_inflight_issue", inflight, 1);
            if (k == 5) begin
               chk("single_resp_valid", resp_valid, onehot(vecs[v].id));
               chk("single_resp_data", resp_data, vecs[v].exp_res);
               chk("single_inflight_done", inflight, 0);
            end else begin
               chk("single_resp_idle", resp_valid, 0);
            end
            tick();
         end
      end
      chk("single_err", err, 0);

      // full contention: rotation 0..3 twice, back-to-back ordered responses
      do_reset();
      set_op(0, 32'h00000000, 32'h3F800000);
      set_op(1, 32'h3F800000, 32'h3F800000);
      set_op(2, 32'h40000000, 32'h3F800000);
      set_op(3, 32'h40400000, 32'h3F800000);
      rq.delete();
      peak = 0;
      req_valid = '1;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("rr_grant", req_ready, onehot(k % 4));
         if (int'(inflight) > peak) peak = int'(inflight);
         tick();
      end
      req_valid = '0;
      for (int k = 0; k < 10; k++) begin
         if (int'(inflight) > peak) peak = int'(inflight);
         tick();
      end
      chk("rr_peak_inflight", peak, 4);
      chk("rr_resp_count", rq.size(), 8);
      for (int j = 0; j < rq.size() && j < 8; j++) begin
         chk("rr_resp_id", rq[j].rv, onehot(j % 4));
         chk("rr_resp_data", rq[j].data, exp_c[j % 4]);
         if (j > 0) chk("rr_resp_b2b", rq[j].cyc, rq[0].cyc + j);
      end

      // hold mid-stream: grants stop, accepted ops drain
      rq.delete();
      set_op(1, 32'h40000000, 32'h3F800000);
      req_valid = 4'b0010;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("hold_pre_grant", req_ready, 4'b0010);
         tick();
      end
      hold = 1'b1;
      #1;
      chk("hold_ready", req_ready, 0);
      chk("hold_inflight_start", inflight, 3);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) chk("hold_ready_later", req_ready, 0);
         if (k == 3) chk("hold_inflight_3", inflight, 1);
         if (k == 4) chk("hold_inflight_4", inflight, 0);
      end
      chk("hold_resp_count", rq.size(), 3);
      for (int j = 0; j < rq.size(); j++) begin
         chk("hold_resp_id", rq[j].rv, 4'b0010);
         chk("hold_resp_data", rq[j].data, 32'h40400000);
      end
      hold = 1'b0;
      req_valid = '0;

      // steady single-requester stream: inflight saturates at LAT+1
      set_op(3, 32'h40400000, 32'h3F800000);
      req_valid = 4'b1000;
      #1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("stream_ready", req_ready, 4'b1000);
         chk("stream_inflight", inflight, (k < 4) ? k : 4);
      end
      req_valid = '0;
      for (int k = 0; k < 8; k++) tick();
      chk("stream_drained", inflight, 0);

      // reset with three operations in flight
      set_op(0, 32'h3F800000, 32'h3F800000);
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) tick();
      chk("rstmid_inflight_before", inflight, 3);
      rq.delete();
      req_valid = '0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("rstmid_no_resp", rq.size(), 0);
      chk("rstmid_inflight", inflight, 0);
      chk("rstmid_err", err, 0);

      // adder out_valid one cycle late: err rises after first mismatch and sticks
      do_reset();
      late = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      set_op(0, 32'h3F800000, 32'h3F800000);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 4) chk("mis_err_before", err, 0);
         if (k == 5) chk("mis_err_set", err, 1);
         tick();
      end
      chk("mis_err_sticky", err, 1);
      late = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      do_reset();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
      $fatal(1);
   end

endmodule
